matmul_datapath: RTL and testbench
==================================

# matmul_datapath

Arithmetic datapath for the N×N matrix multiplier, directly downstream of the multiplier control FSM. It holds operand matrices A and B, which are written element-by-element through a host write port. It is armed by the control's `load_A_B` strobe and computes C = A·B with a single multiply-accumulate unit while `start_mul` is high. It reports completion on `done_datapath` and exposes C through a registered read port.

## Interface
Parameters:
- `N`, 10: matrix dimension (N ≥ 2).
- `DW`, 8: unsigned operand width.
- `CW`, 2*DW+$clog2(N): result and accumulator width; derived, not overridden.
- `AW`, $clog2(N*N): flat element address width; address = row*N + col.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_A_B` in 1: arm strobe from control; any high cycle arms the block.
- `start_mul` in 1: level from control; compute request.
- `done_datapath` out 1: one-cycle completion pulse to control.
- `busy` out 1: high while computing.
- `wr_en` in 1: operand write strobe.
- `wr_sel` in 1: 0 = A, 1 = B.
- `wr_addr` in AW: flat element address.
- `wr_data` in DW: operand value.
- `rd_addr` in AW: C element address.
- `rd_data` out CW: C element, registered.

## Operation
- States: IDLE, MAC, WB, DONE.
- Arming:
  - `load_A_B` sampled high sets the `armed` flag.
  - It also zeroes the indices i, j, k and the accumulator.
  - It is ignored outside IDLE.
- Transitions:
  - IDLE→MAC when `start_mul && armed`. Entering MAC clears `armed`.
  - `start_mul` without `armed` leaves the block in IDLE indefinitely.
  - MAC:
    - Each cycle computes acc ← (k==0 ? 0 : acc) + A[i][k]·B[k][j].
    - k increments each cycle.
    - After the cycle with k==N−1, go to WB.
  - WB:
    - Write C[i][j] ← acc.
    - Advance j; when j wraps from N−1 to 0, advance i.
    - Go to MAC, or to DONE if (i,j) was (N−1,N−1).
  - DONE lasts exactly one cycle; DONE→IDLE unconditionally.
- Outputs:
  - `done_datapath` = (state==DONE), a Moore output.
  - `busy` = state ∈ {MAC, WB}.
- Arithmetic:
  - Unsigned DW×DW product, zero-extended to CW.
  - CW is sized so that N·(2^DW−1)² never overflows; no saturation logic.
- Write port:
  - Honoured only in IDLE; ignored in all other states.
  - Addresses ≥ N*N are ignored.
- Read port:
  - `rd_data` ← C[rd_addr] every cycle.
  - Addresses ≥ N*N read as 0.
  - While busy, C holds a mix of new and previous results.
- Restart:
  - A new computation requires a new `load_A_B`.
  - `start_mul` held high after DONE does not recompute.

## Timing
- Reset:
  - State returns to IDLE.
  - `armed`, indices, accumulator and A, B, C arrays are cleared to 0.
  - `done_datapath`, `busy` and `rd_data` are 0.
- Reset mid-operation aborts immediately. No DONE pulse is produced, and C reads 0 afterwards.
- Latency:
  - Let cycle 0 be the cycle in which `start_mul` is first sampled high with `armed` set.
  - `busy` is high on cycles 1 .. N²(N+1).
  - `done_datapath` is high on cycle N²(N+1)+1 only.
  - For N=10 that is cycle 1101; for N=2, cycle 13.
- With the control FSM:
  - `load_A_B` is high for 2 cycles.
  - `start_mul` rises the cycle after the second `load_A_B` cycle.
  - The control returns to IDLE on the DONE cycle and drops `start_mul` on the next cycle; the datapath is already in IDLE by then.
- `load_A_B` and `start_mul` high in the same IDLE cycle:
  - The arm takes effect at that edge; the start is not taken.
  - MAC begins on the following edge if `start_mul` is still high.
- `rd_data` latency is 1 cycle.
- A write sampled at edge t is visible to a MAC operand read from cycle t+1.

## Structure
- Shared package `matmul_pkg` holds:
  - the state enum (IDLE, MAC, WB, DONE);
  - the default `DW`;
  - the `CW` and `AW` derivation functions, so the control and testbench use identical widths.
- Sub-module `matmul_mac`:
  - combinational unsigned multiply of two DW operands;
  - CW accumulator register with a synchronous `clr_acc` (k==0) and enable;
  - synchronous reset on `rst`.
- The operand/result arrays and index counters stay in the top module.

## Test plan
- **Identity check**, N=2: A = I, B = {1,2,3,4}, arm, hold `start_mul`. Required:
  - `done_datapath` on cycle 13;
  - C reads back {1,2,3,4};
  - `busy` high on cycles 1–12.
- **Worst-case magnitude**, N=10, DW=8: all A, B = 255. Required:
  - every C element = 650250 (fits in 20 bits);
  - `done_datapath` on cycle 1101.
- **No arm**: `start_mul` held high for 50 cycles without `load_A_B`. Required:
  - state stays IDLE;
  - `busy` = 0, `done_datapath` = 0.
- **Re-run and write blocking**: after DONE, keep `start_mul` high. Required:
  - no second `busy` or done.
  - Then write A[0]=5 while busy on a re-armed run: the write is ignored, and C matches the original A.
- **Reset mid-run**: N=2, assert `rst` on cycle 6. Required:
  - `busy` = 0 from the next cycle;
  - no done pulse;
  - all C reads = 0;
  - the next arm+start completes normally at cycle 13.
- **Out-of-range addresses**: write to `wr_addr` = N*N and read at `rd_addr` = N*N. Required:
  - arrays unchanged;
  - `rd_data` = 0 one cycle after the read address is applied.

Source files
------------

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and width derivations for the matrix multiplier
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_DW = 8;

  // Accumulator wide enough that n*(2^dw-1)^2 cannot overflow.
  function automatic int calc_cw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int calc_aw(input int n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - unsigned multiply-accumulate unit for the matrix multiplier
module matmul_mac #(
  parameter int DW = 8,
  parameter int CW = 2 * DW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr_acc,
  input  logic          zero_acc,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [CW-1:0] acc
);

  logic [2*DW-1:0] prod;

  assign prod = a * b;

  // clr_acc starts a new dot product by dropping the previous sum
  always_ff @(posedge clk) begin
    if (rst || zero_acc) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr_acc ? '0 : acc) + CW'(prod);
    end
  end

endmodule

// File: rtl/matmul_datapath.sv
// rtl/matmul_datapath.sv - operand/result storage and sequencing for C = A*B with one MAC
module matmul_datapath
  import matmul_pkg::*;
#(
  parameter int  N  = 10,
  parameter int  DW = DEFAULT_DW,
  localparam int CW = calc_cw(N, DW),
  localparam int AW = calc_aw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_A_B,
  input  logic          start_mul,
  output logic          done_datapath,
  output logic          busy,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);

  localparam int            IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [AW:0]   NN   = (AW + 1)'(N * N);

  state_t        state, state_nxt;
  logic          armed;
  logic          arm;
  logic [IW-1:0] i, j, k;
  logic [AW-1:0] a_idx, b_idx, c_idx;
  logic          wr_ok, rd_ok;
  logic [CW-1:0] acc;

  logic [DW-1:0] a_mem [N*N];
  logic [DW-1:0] b_mem [N*N];
  logic [CW-1:0] c_mem [N*N];

  assign arm   = (state == IDLE) && load_A_B;
  assign a_idx = AW'(int'(i) * N + int'(k));
  assign b_idx = AW'(int'(k) * N + int'(j));
  assign c_idx = AW'(int'(i) * N + int'(j));
  assign wr_ok = ({1'b0, wr_addr} < NN);
  assign rd_ok = ({1'b0, rd_addr} < NN);

  assign done_datapath = (state == DONE);
  assign busy          = (state == MAC) || (state == WB);

  // An arm in the same cycle as a start wins; the start is re-evaluated next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_mul && armed && !load_A_B) state_nxt = MAC;
      MAC:     if (k == LAST) state_nxt = WB;
      WB:      state_nxt = (i == LAST && j == LAST) ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        armed <= 1'b1;
        i     <= '0;
        j     <= '0;
        k     <= '0;
      end else if (state == IDLE && state_nxt == MAC) begin
        armed <= 1'b0;
      end
      if (state == MAC) begin
        k <= (k == LAST) ? '0 : k + 1'b1;
      end
      if (state == WB) begin
        if (j == LAST) begin
          j <= '0;
          i <= (i == LAST) ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N * N; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
        c_mem[n] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (state == IDLE && wr_en && wr_ok) begin
        if (wr_sel) b_mem[wr_addr] <= wr_data;
        else        a_mem[wr_addr] <= wr_data;
      end
      if (state == WB) begin
        c_mem[c_idx] <= acc;
      end
      rd_data <= rd_ok ? c_mem[rd_addr] : '0;
    end
  end

  matmul_mac #(
    .DW (DW),
    .CW (CW)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (state == MAC),
    .clr_acc  (k == '0),
    .zero_acc (arm),
    .a        (a_mem[a_idx]),
    .b        (b_mem[b_idx]),
    .acc      (acc)
  );

endmodule

// File: tb/tb_matmul_datapath.sv
// tb/tb_matmul_datapath.sv - directed self-checking bench for matmul_datapath at N=2 and N=10
module tb_matmul_datapath;
  import matmul_pkg::*;

  localparam int AW2  = calc_aw(2);
  localparam int CW2  = calc_cw(2, DEFAULT_DW);
  localparam int AW10 = calc_aw(10);
  localparam int CW10 = calc_cw(10, DEFAULT_DW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst2, ld2, st2, done2, busy2, we2, ws2;
  logic [AW2-1:0]  wa2, ra2;
  logic [7:0]      wd2;
  logic [CW2-1:0]  rd2;

  logic            rst10, ld10, st10, done10, busy10, we10, ws10;
  logic [AW10-1:0] wa10, ra10;
  logic [7:0]      wd10;
  logic [CW10-1:0] rd10;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] v;
  int bc, dc;

  int a_id  [4] = '{1, 0, 0, 1};
  int b_seq [4] = '{1, 2, 3, 4};
  int a_seq [4] = '{1, 2, 3, 4};
  int b_two [4] = '{5, 6, 7, 8};
  int c_two [4] = '{19, 22, 43, 50};

  matmul_datapath #(.N(2), .DW(DEFAULT_DW)) u_n2 (
    .clk(clk), .rst(rst2), .load_A_B(ld2), .start_mul(st2),
    .done_datapath(done2), .busy(busy2), .wr_en(we2), .wr_sel(ws2),
    .wr_addr(wa2), .wr_data(wd2), .rd_addr(ra2), .rd_data(rd2)
  );

  matmul_datapath #(.N(10), .DW(DEFAULT_DW)) u_n10 (
    .clk(clk), .rst(rst10), .load_A_B(ld10), .start_mul(st10),
    .done_datapath(done10), .busy(busy10), .wr_en(we10), .wr_sel(ws10),
    .wr_addr(wa10), .wr_data(wd10), .rd_addr(ra10), .rd_data(rd10)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit big, input bit sel, input int addr, input int data);
    if (big) begin we10 = 1'b1; ws10 = sel; wa10 = AW10'(addr); wd10 = 8'(data); end
    else     begin we2  = 1'b1; ws2  = sel; wa2  = AW2'(addr);  wd2  = 8'(data); end
    tick();
    we10 = 1'b0;
    we2  = 1'b0;
  endtask

  task automatic rd(input bit big, input int addr, output logic [63:0] val);
    if (big) ra10 = AW10'(addr);
    else     ra2  = AW2'(addr);
    tick();
    val = big ? 64'(rd10) : 64'(rd2);
  endtask

  task automatic load2(input int a [4], input int b [4]);
    for (int e = 0; e < 4; e++) begin
      wr(1'b0, 1'b0, e, a[e]);
      wr(1'b0, 1'b1, e, b[e]);
    end
  endtask

  // Mimics the control: 2-cycle arm, then start held through DONE and beyond.
  task automatic run(input bit big, input int rst_at, input bit inject, input string tag);
    int  t, done_cyc, done_cnt, busy_err;
    bit  b, d, be;
    t        = big ? 1100 : 12;
    done_cyc = -1;
    done_cnt = 0;
    busy_err = 0;
    if (big) ld10 = 1'b1; else ld2 = 1'b1;
    tick();
    tick();
    ld10 = 1'b0;
    ld2  = 1'b0;
    if (big) st10 = 1'b1; else st2 = 1'b1;
    for (int n = 1; n <= t + 20; n++) begin
      tick();
      b  = big ? busy10 : busy2;
      d  = big ? done10 : done2;
      be = (n <= t) && !(rst_at > 0 && n > rst_at);
      if (b != be) busy_err++;
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (rst_at > 0 && n == rst_at) begin
        if (big) rst10 = 1'b1; else rst2 = 1'b1;
      end
      if (rst_at > 0 && n == rst_at + 1) begin
        rst10 = 1'b0;
        rst2  = 1'b0;
      end
      if (inject && n == 3) begin
        if (big) begin we10 = 1'b1; ws10 = 1'b0; wa10 = '0; wd10 = 8'd5; end
        else     begin we2  = 1'b1; ws2  = 1'b0; wa2  = '0; wd2  = 8'd5; end
      end
      if (inject && n == 4) begin
        we10 = 1'b0;
        we2  = 1'b0;
      end
    end
    st2  = 1'b0;
    st10 = 1'b0;
    tick();
    check({tag, " busy_window_errs"}, 64'(busy_err), 64'd0);
    if (rst_at > 0) begin
      check({tag, " done_count"}, 64'(done_cnt), 64'd0);
    end else begin
      check({tag, " done_cycle"}, 64'(done_cyc), 64'(t + 1));
      check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    end
  endtask

  initial begin
    rst2 = 1'b1; ld2 = 1'b0; st2 = 1'b0; we2 = 1'b0; ws2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;
    rst10 = 1'b1; ld10 = 1'b0; st10 = 1'b0; we10 = 1'b0; ws10 = 1'b0; wa10 = '0; wd10 = '0; ra10 = '0;
    repeat (3) tick();
    rst2  = 1'b0;
    rst10 = 1'b0;

    check("reset busy2", 64'(busy2), 64'd0);
    check("reset done2", 64'(done2), 64'd0);
    check("reset rd2", 64'(rd2), 64'd0);
    check("reset busy10", 64'(busy10), 64'd0);
    check("reset done10", 64'(done10), 64'd0);
    check("reset rd10", 64'(rd10), 64'd0);

    st2 = 1'b1;
    bc  = 0;
    dc  = 0;
    repeat (50) begin
      tick();
      bc += int'(busy2);
      dc += int'(done2);
    end
    st2 = 1'b0;
    check("noarm busy_cycles", 64'(bc), 64'd0);
    check("noarm done_cycles", 64'(dc), 64'd0);

    load2(a_id, b_seq);
    run(1'b0, 0, 1'b0, "ident");
    for (int e = 0; e < 4; e++) begin
      rd(1'b0, e, v);
      check($sformatf("ident C%0d", e), v, 64'(b_seq[e]));
    end

    load2(a_seq, b_two);
    run(1'b0, 0, 1'b1, "wrblock");
    for (int e = 0; e < 4; e++) begin
      rd(1'b0, e, v);
      check($sformatf("wrblock C%0d", e), v, 64'(c_two[e]));
    end

    run(1'b0, 6, 1'b0, "rstmid");
    for (int e = 0; e < 4; e++) begin
      rd(1'b0, e, v);
      check($sformatf("rstmid C%0d", e), v, 64'd0);
    end
    load2(a_seq, b_two);
    run(1'b0, 0, 1'b0, "after_rst");
    for (int e = 0; e < 4; e++) begin
      rd(1'b0, e, v);
      check($sformatf("after_rst C%0d", e), v, 64'(c_two[e]));
    end

    for (int e = 0; e < 100; e++) begin
      wr(1'b1, 1'b0, e, 255);
      wr(1'b1, 1'b1, e, 255);
    end
    run(1'b1, 0, 1'b0, "worst");
    for (int e = 0; e < 100; e++) begin
      rd(1'b1, e, v);
      check($sformatf("worst C%0d", e), v, 64'd650250);
    end

    wr(1'b1, 1'b0, 100, 0);
    wr(1'b1, 1'b1, 100, 0);
    rd(1'b1, 100, v);
    check("oor rd100", v, 64'd0);
    rd(1'b1, 0, v);
    check("oor rd0", v, 64'd650250);
    rd(1'b1, 127, v);
    check("oor rd127", v, 64'd0);
    run(1'b1, 0, 1'b0, "oor_rerun");
    rd(1'b1, 0, v);
    check("oor_rerun C0", v, 64'd650250);
    rd(1'b1, 55, v);
    check("oor_rerun C55", v, 64'd650250);
    rd(1'b1, 99, v);
    check("oor_rerun C99", v, 64'd650250);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
